// File: rtl/bus_dma_host.sv
// rtl/bus_dma_host.sv - single-channel word-copy DMA engine with register port and bus host
module bus_dma_host #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int LenWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [3:0]              dev_be_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    host_req_o,
  input  logic                    host_gnt_i,
  output logic [AddressWidth-1:0] host_addr_o,
  output logic                    host_we_o,
  output logic [3:0]              host_be_o,
  output logic [DataWidth-1:0]    host_wdata_o,
  input  logic                    host_rvalid_i,
  input  logic [DataWidth-1:0]    host_rdata_i,
  input  logic                    host_err_i,
  output logic                    dma_irq_o
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;
  state_e state_q, state_d;

  logic [AddressWidth-1:0] src_q, dst_q, cur_src_q, cur_dst_q;
  logic [LenWidth-1:0]     len_q, remaining_q;
  logic [DataWidth-1:0]    buf_q, rdata_q;
  logic                    irq_en_q, done_q, err_q, rvalid_q;

  logic                    busy, reg_wr, ctrl_wr, start;
  logic                    rd_resp, wr_resp, finish, finish_err;
  logic [DataWidth-1:0]    be_mask, rd_mux, src_wr, dst_wr, len_wr;
  logic                    unused_bits;

  assign busy    = (state_q != IDLE);
  assign reg_wr  = dev_req_i & dev_we_i;
  assign ctrl_wr = reg_wr & (dev_addr_i[3:2] == 2'd3);
  assign start   = ctrl_wr & dev_wdata_i[0] & ~busy;

  // Byte-lane merge of the write data into the current register value
  assign be_mask = {{8{dev_be_i[3]}}, {8{dev_be_i[2]}}, {8{dev_be_i[1]}}, {8{dev_be_i[0]}}};
  assign src_wr  = (DataWidth'(src_q) & ~be_mask) | (dev_wdata_i & be_mask);
  assign dst_wr  = (DataWidth'(dst_q) & ~be_mask) | (dev_wdata_i & be_mask);
  assign len_wr  = (DataWidth'(len_q) & ~be_mask) | (dev_wdata_i & be_mask);

  assign unused_bits = ^{dev_addr_i[AddressWidth-1:4], dev_addr_i[1:0], src_wr[1:0],
                         dst_wr[1:0], len_wr[DataWidth-1:LenWidth]};

  always_comb begin
    rd_mux = '0;
    case (dev_addr_i[3:2])
      2'd0:    rd_mux = DataWidth'(src_q);
      2'd1:    rd_mux = DataWidth'(dst_q);
      2'd2:    rd_mux = DataWidth'(len_q);
      default: rd_mux = DataWidth'({err_q, done_q, irq_en_q, busy});
    endcase
  end

  // A response may arrive in the same cycle as the grant
  assign rd_resp = host_rvalid_i & ((state_q == RD_WAIT) | ((state_q == RD_REQ) & host_gnt_i));
  assign wr_resp = host_rvalid_i & ((state_q == WR_WAIT) | ((state_q == WR_REQ) & host_gnt_i));
  assign finish_err = (rd_resp | wr_resp) & host_err_i;
  assign finish     = finish_err | (wr_resp & (remaining_q == LenWidth'(1)));

  always_comb begin
    state_d     = state_q;
    host_req_o  = 1'b0;
    host_we_o   = 1'b0;
    host_addr_o = '0;
    case (state_q)
      IDLE: begin
        if (start && (len_q != '0)) state_d = RD_REQ;
      end
      RD_REQ, RD_WAIT: begin
        host_req_o  = (state_q == RD_REQ);
        host_addr_o = cur_src_q;
        if (rd_resp)                                 state_d = host_err_i ? IDLE : WR_REQ;
        else if ((state_q == RD_REQ) && host_gnt_i)  state_d = RD_WAIT;
      end
      WR_REQ, WR_WAIT: begin
        host_req_o  = (state_q == WR_REQ);
        host_we_o   = (state_q == WR_REQ);
        host_addr_o = cur_dst_q;
        if (wr_resp)                                 state_d = finish ? IDLE : RD_REQ;
        else if ((state_q == WR_REQ) && host_gnt_i)  state_d = WR_WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= dev_req_i;
      rdata_q  <= (dev_req_i && !dev_we_i) ? rd_mux : '0;
      if (reg_wr && !busy) begin
        case (dev_addr_i[3:2])
          2'd0:    src_q <= {src_wr[AddressWidth-1:2], 2'b00};
          2'd1:    dst_q <= {dst_wr[AddressWidth-1:2], 2'b00};
          2'd2:    len_q <= len_wr[LenWidth-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        irq_en_q <= dev_wdata_i[1];
        if (dev_wdata_i[2]) done_q <= 1'b0;
      end
      if (start) begin
        done_q      <= (len_q == '0);
        err_q       <= 1'b0;
        cur_src_q   <= src_q;
        cur_dst_q   <= dst_q;
        remaining_q <= len_q;
      end
      if (rd_resp) buf_q <= host_rdata_i;
      if (wr_resp) begin
        cur_src_q   <= cur_src_q + AddressWidth'(4);
        cur_dst_q   <= cur_dst_q + AddressWidth'(4);
        remaining_q <= remaining_q - LenWidth'(1);
      end
      // Completion overrides a same-cycle DONE clear
      if (finish) begin
        done_q <= 1'b1;
        if (finish_err) err_q <= 1'b1;
      end
    end
  end

  assign dev_rvalid_o = rvalid_q;
  assign dev_rdata_o  = rdata_q;
  assign dev_err_o    = 1'b0;
  assign host_be_o    = 4'hF;
  assign host_wdata_o = buf_q;
  assign dma_irq_o    = done_q & irq_en_q;
endmodule
